// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode and funct
// encodings, ALUControl encodings, ALUOp encodings and the FSM state type.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp: what the controller asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14
  } state_e;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder.
//   ALUOp         in  2  00 = add, 01 = sub, 10 = decode Funct
//   Funct         in  6  R-type funct field
//   ALUControl    out 3  ALU operation
//   Funct_Illegal out 1  Funct not supported (only meaningful for ALUOp = 10)
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       Funct_Illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ALUControl    = ALU_ADD;
    Funct_Illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: Funct_Illegal = 1'b1;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle MIPS datapath.
//   clk_Control / rst_Control : clock, asynchronous active-low reset
//   Opcode, Funct, Zero       : instruction fields and ALU zero flag
//   Mem_Ready                 : memory completes the current access
//   Mem_Req, MemWrite, IorD   : memory port control
//   IRWrite, PC_En, PCSrc     : instruction register / PC control
//   ALUSrcA, ALUSrcB, ALUControl : ALU operand selects and operation
//   RegWrite, RegDst, MemToReg   : register file write-back control
//   Illegal_Op                : sticky illegal-instruction flag
//   Instr_Count               : retired-instruction counter (wraps)
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk_Control,
  input  logic             rst_Control,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             Mem_Req,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PC_En,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             Illegal_Op,
  output logic [CNT_W-1:0] Instr_Count
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       retire;
  logic       pc_write;
  logic       branch;
  logic       alu_use;
  alu_op_e    alu_op;
  logic [2:0] dec_alu_control;
  logic       funct_illegal;

  alu_decoder u_alu_decoder (
    .ALUOp         (alu_op),
    .Funct         (Funct),
    .ALUControl    (dec_alu_control),
    .Funct_Illegal (funct_illegal)
  );

  // State, sticky flag and counter registers.
  always_ff @(posedge clk_Control or negedge rst_Control) begin
    if (!rst_Control) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. Retiring states assert retire on the cycle they leave.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (Mem_Ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (Mem_Ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (Mem_Ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = funct_illegal ? S_ILLEGAL : S_ALUWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ILLEGAL: begin
        illegal_d = 1'b1;
        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // Moore output decode; only IRWrite/PCWrite in S_FETCH look at Mem_Ready.
  always_comb begin
    Mem_Req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    pc_write = 1'b0;
    branch   = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    alu_use  = 1'b0;
    alu_op   = ALUOP_ADD;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        Mem_Req  = 1'b1;
        ALUSrcB  = 2'b01;
        alu_use  = 1'b1;
        IRWrite  = Mem_Ready;
        pc_write = Mem_Ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        alu_use = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_use = 1'b1;
      end
      S_MEMRD: begin
        Mem_Req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        Mem_Req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_use = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_use = 1'b1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // ALUControl is forced to 0 in states that do not use the ALU.
  assign ALUControl  = alu_use ? dec_alu_control : 3'b000;
  assign PC_En       = pc_write | (branch & Zero);
  assign Illegal_Op  = illegal_q;
  assign Instr_Count = count_q;

endmodule
